// File: rtl/wt_store_wbuf.sv
// wt_store_wbuf: write-through store buffer with out-of-order acks,
// in-order retirement, a load-hazard word-address check and optional
// same-word coalescing (enabled by defining WT_STORE_WBUF_COALESCE_EN).
module wt_store_wbuf #(
  parameter int  DEPTH  = 2,
  parameter int  ADDR_W = 64,
  parameter int  DATA_W = 64,
  parameter int  ID_W   = $clog2(DEPTH),
  localparam int BE_W   = DATA_W/8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [ID_W-1:0]   mem_id_o,
  input  logic              ack_valid_i,
  input  logic [ID_W-1:0]   ack_id_i,
  input  logic [ADDR_W-1:0] chk_addr_i,
  output logic              chk_hit_o,
  output logic              empty_o,
  output logic              ack_err_o
);
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {FREE, PEND, INFL} st_e;

  typedef struct packed {
    logic [WA_W-1:0]   waddr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } ent_t;

  st_e              st_q  [DEPTH];
  ent_t             ent_q [DEPTH];
  logic [ID_W-1:0]  tail_q, iss_q, head_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_err_q;

  logic [WA_W-1:0]  req_waddr, chk_waddr;
  logic [ID_W-1:0]  young;
  logic             coal_hit, full, do_alloc, do_coal, do_iss, ack_ok, retire;
  logic [DEPTH-1:0] hit_vec, free_vec;
  logic             unused_lo;

  assign req_waddr = req_addr_i[ADDR_W-1:OFF_W];
  assign chk_waddr = chk_addr_i[ADDR_W-1:OFF_W];
  assign unused_lo = ^{req_addr_i[OFF_W-1:0], chk_addr_i[OFF_W-1:0]};

  // PEND entries are contiguous from iss to tail-1, so the youngest PEND
  // candidate is always the last allocated slot.
  assign young = tail_q - ID_W'(1);

`ifdef WT_STORE_WBUF_COALESCE_EN
  // Never merge into the entry currently presented to memory.
  assign coal_hit = req_valid_i && (st_q[young] == PEND) &&
                    (ent_q[young].waddr == req_waddr) &&
                    !((young == iss_q) && mem_valid_o);
`else
  assign coal_hit = 1'b0;
`endif

  assign full        = (cnt_q == CNT_W'(DEPTH));
  assign req_ready_o = !full || coal_hit;
  assign do_alloc    = req_valid_i && req_ready_o && !coal_hit;
  assign do_coal     = req_valid_i && coal_hit;

  assign mem_valid_o = (st_q[iss_q] == PEND);
  assign mem_addr_o  = {ent_q[iss_q].waddr, {OFF_W{1'b0}}};
  assign mem_data_o  = ent_q[iss_q].data;
  assign mem_be_o    = ent_q[iss_q].be;
  assign mem_id_o    = iss_q;
  assign do_iss      = mem_valid_o && mem_ready_i;

  assign ack_ok = ack_valid_i && (st_q[ack_id_i] == INFL);
  // An ack to the head frees and retires it on the same edge.
  assign retire = (cnt_q != '0) &&
                  ((st_q[head_q] == FREE) || (ack_ok && (ack_id_i == head_q)));

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign free_vec[g] = (st_q[g] == FREE);
    assign hit_vec[g]  = !free_vec[g] && (ent_q[g].waddr == chk_waddr);
  end

  assign chk_hit_o = |hit_vec;
  assign empty_o   = &free_vec;
  assign ack_err_o = ack_err_q;

  // Entry state, pointers and count; alloc/issue/ack touch distinct entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= FREE;
        ent_q[i] <= '0;
      end
      tail_q    <= '0;
      iss_q     <= '0;
      head_q    <= '0;
      cnt_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      if (do_alloc) begin
        st_q[tail_q]  <= PEND;
        ent_q[tail_q] <= '{waddr: req_waddr, data: req_data_i, be: req_be_i};
        tail_q        <= tail_q + ID_W'(1);
      end
      if (do_coal) begin
        for (int b = 0; b < BE_W; b++)
          if (req_be_i[b]) ent_q[young].data[8*b +: 8] <= req_data_i[8*b +: 8];
        ent_q[young].be <= ent_q[young].be | req_be_i;
      end
      if (do_iss) begin
        st_q[iss_q] <= INFL;
        iss_q       <= iss_q + ID_W'(1);
      end
      if (ack_valid_i) begin
        if (ack_ok) st_q[ack_id_i] <= FREE;
        else        ack_err_q      <= 1'b1;
      end
      if (retire) head_q <= head_q + ID_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_alloc) - CNT_W'(retire);
    end
  end
endmodule

// File: tb/tb_wt_store_wbuf.sv
// Directed bench for wt_store_wbuf (DEPTH=4, DATA_W=64).
module tb_wt_store_wbuf;
  localparam int DEPTH = 4, ADDR_W = 64, DATA_W = 64, BE_W = 8, ID_W = 2;
`ifdef WT_STORE_WBUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic              clk = 1'b0, rst = 1'b1;
  logic              req_valid = 1'b0, req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic [BE_W-1:0]   req_be = '0;
  logic              mem_valid, mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0]   mem_be;
  logic [ID_W-1:0]   mem_id;
  logic              ack_valid = 1'b0;
  logic [ID_W-1:0]   ack_id = '0;
  logic [ADDR_W-1:0] chk_addr = '0;
  logic              chk_hit, empty, ack_err;

  int n_chk = 0, n_pass = 0;

  wt_store_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_id_o(mem_id),
    .ack_valid_i(ack_valid), .ack_id_i(ack_id),
    .chk_addr_i(chk_addr), .chk_hit_o(chk_hit), .empty_o(empty), .ack_err_o(ack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    req_valid = 1'b1; req_addr = a; req_data = d; req_be = be;
  endtask

  task automatic ack(input logic [ID_W-1:0] id);
    ack_valid = 1'b1; ack_id = id;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0; ack_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    rst = 1'b0; #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_empty",     empty, 1);
    check("rst_chk_hit",   chk_hit, 0);
    check("rst_ack_err",   ack_err, 0);

    // single store: one-cycle latency, ack retires it
    put(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    tick(); req_valid = 1'b0;
    chk_addr = 64'h8000_0014; #1;
    check("one_valid", mem_valid, 1);
    check("one_addr",  mem_addr, 64'h8000_0010);
    check("one_data",  mem_data, 64'h1122_3344_5566_7788);
    check("one_be",    mem_be, 8'hFF);
    check("one_id",    mem_id, 0);
    check("one_hit",   chk_hit, 1);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; #1;
    check("one_issued", mem_valid, 0);
    check("one_busy",   empty, 0);
    ack(0); #1;
    check("one_empty", empty, 1);
    check("one_cnt",   dut.cnt_q, 0);
    check("one_nohit", chk_hit, 0);

    // full: 4 accepted, 5th blocked until one cycle after the ack
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      put(64'h1000 + 64'(i*8), 64'(i), 8'hFF); #1;
      check("full_rdy", req_ready, 1);
      tick();
    end
    put(64'h1020, 64'hDEAD, 8'hFF); #1;
    check("full_block", req_ready, 0);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; #1;
    check("full_hold", req_ready, 0);
    ack(0); #1;
    check("full_recover", req_ready, 1);
    tick(); req_valid = 1'b0; #1;
    check("full_again", req_ready, 0);
    check("full_next_id",   mem_id, 1);
    check("full_next_addr", mem_addr, 64'h1008);

    // out-of-order acks retire in order
    rst_pulse();
    mem_ready = 1'b1;
    put(64'h2000, 64'hA0, 8'hFF); tick();
    check("ooo_id0", mem_id, 0);
    put(64'h2008, 64'hA1, 8'hFF); tick();
    check("ooo_id1", mem_id, 1);
    put(64'h2010, 64'hA2, 8'hFF); tick();
    check("ooo_id2",   mem_id, 2);
    check("ooo_addr2", mem_addr, 64'h2010);
    req_valid = 1'b0; tick(); mem_ready = 1'b0; #1;
    check("ooo_all_issued", mem_valid, 0);
    check("ooo_cnt3", dut.cnt_q, 3);
    ack(2);
    chk_addr = 64'h2010; #1;
    check("ooo_ack2_cnt", dut.cnt_q, 3);
    check("ooo_ack2_nohit", chk_hit, 0);
    chk_addr = 64'h2000; #1;
    check("ooo_ack2_hit0", chk_hit, 1);
    ack(0); #1;
    check("ooo_ack0_cnt", dut.cnt_q, 2);
    check("ooo_ack0_busy", empty, 0);
    ack(1); #1;
    check("ooo_ack1_cnt", dut.cnt_q, 1);
    check("ooo_ack1_empty", empty, 1);
    tick();
    check("ooo_final_cnt", dut.cnt_q, 0);
    check("ooo_no_err", ack_err, 0);

    // coalescing (or two separate writes without the feature)
    rst_pulse();
    put(64'h800,  64'hAAAA_AAAA_AAAA_AAAA, 8'hFF); tick();
    put(64'h1000, 64'h5555_5555_1122_3344, 8'h0F); tick();
    put(64'h1004, 64'h9988_7766_CCCC_CCCC, 8'hF0); #1;
    check("coal_rdy", req_ready, 1);
    tick(); req_valid = 1'b0;
    check("coal_cnt", dut.cnt_q, COAL ? 2 : 3);
    mem_ready = 1'b1; tick();
    check("coal_w1_id",   mem_id, 1);
    check("coal_w1_addr", mem_addr, 64'h1000);
    check("coal_w1_be",   mem_be, COAL ? 8'hFF : 8'h0F);
    check("coal_w1_data", mem_data, COAL ? 64'h9988_7766_1122_3344 : 64'h5555_5555_1122_3344);
    tick(); mem_ready = 1'b0; #1;
    check("coal_w2_valid", mem_valid, COAL ? 0 : 1);
    check("coal_w2_be",    mem_be, COAL ? 8'h00 : 8'hF0);

    // load hazard check
    rst_pulse();
    put(64'h8000_0040, 64'h1, 8'hFF);
    chk_addr = 64'h8000_0044; #1;
    check("haz_same_cycle", chk_hit, 0);
    tick(); req_valid = 1'b0; #1;
    check("haz_pend", chk_hit, 1);
    chk_addr = 64'h8000_0048; #1;
    check("haz_other_word", chk_hit, 0);
    chk_addr = 64'h8000_0044;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; #1;
    check("haz_infl", chk_hit, 1);
    ack(0); #1;
    check("haz_retired", chk_hit, 0);

    // stray ack: sticky error, no state change
    rst_pulse();
    ack(3); #1;
    check("err_set",   ack_err, 1);
    check("err_empty", empty, 1);
    check("err_cnt",   dut.cnt_q, 0);
    check("err_mem",   mem_valid, 0);
    tick(); tick();
    check("err_sticky", ack_err, 1);
    rst_pulse(); #1;
    check("err_clr", ack_err, 0);

    // reset mid-flight drops the entry; its late ack is an error
    put(64'h3000, 64'h7, 8'hFF); tick(); req_valid = 1'b0;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    check("late_busy", empty, 0);
    rst_pulse(); #1;
    check("late_rst_empty", empty, 1);
    ack(0); #1;
    check("late_ack_err", ack_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wt_store_wbuf.md
# wt_store_wbuf

Parametrised write-through store buffer between the CVA6 store unit and the write-through data-cache memory port. Generalises the fixed two-entry write buffer to configurable depth, data width and ID width. Adds out-of-order acknowledge, a load-hazard address check and optional same-word store coalescing. Stores issue to memory in program order and stay resident until their write is acknowledged.

## Interface
- DEPTH, 2: number of entries; power of two, ≥2.
- ADDR_W, 64: byte address width.
- DATA_W, 64: data width; power of two, ≥32. BE_W = DATA_W/8.
- ID_W, $clog2(DEPTH): memory transaction ID width; equals the entry index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  store request valid.
- req_ready_o  out  1  store request accepted this cycle when high with req_valid_i.
- req_addr_i  in  ADDR_W  store byte address.
- req_data_i  in  DATA_W  store data, lane-aligned.
- req_be_i  in  BE_W  byte enables.
- mem_valid_o  out  1  write presented to memory.
- mem_ready_i  in  1  memory accepts the write.
- mem_addr_o  out  ADDR_W  word-aligned address; low $clog2(BE_W) bits are zero.
- mem_data_o  out  DATA_W  write data.
- mem_be_o  out  BE_W  byte enables.
- mem_id_o  out  ID_W  entry index used as the transaction ID.
- ack_valid_i  in  1  write acknowledge.
- ack_id_i  in  ID_W  ID being acknowledged; acks may arrive in any order.
- chk_addr_i  in  ADDR_W  load address for the hazard check.
- chk_hit_o  out  1  a non-FREE entry holds the same word address.
- empty_o  out  1  all entries FREE.
- ack_err_o  out  1  sticky: an ack was received for an entry that is not INFL.

## Operation
- Word address: addr[ADDR_W-1:$clog2(BE_W)].
- Each entry is in one of three states: FREE, PEND (waiting to issue) or INFL (issued, awaiting ack). Each entry also holds a word address, data and byte enables.
- Pointers: alloc (tail), iss (next to issue), head (oldest). A count tracks non-FREE entries.
- Allocate: on req_valid_i && req_ready_o with no coalesce, the tail entry becomes PEND and the tail increments modulo DEPTH.
- Issue: mem_valid_o = (entry[iss] is PEND). It is driven from registers only.
  - On mem_ready_i, the entry becomes INFL and iss increments.
  - While mem_valid_o is high, the addr, data, be and id outputs are held stable.
- Ack: on ack_valid_i with entry[ack_id_i] INFL, the entry becomes FREE.
  - An ack to any other state is ignored and sets ack_err_o.
- Head advance: when entry[head] is FREE and count>0, head increments, at most one entry per cycle. Out-of-order frees therefore retire in order.
- req_ready_o = (count < DEPTH) || coalesce_hit. Combinational from the request.
- chk_hit_o: combinational compare of chk_addr_i against every PEND or INFL entry.
- Simultaneous events in one cycle are all honoured: allocate, issue, ack and head advance. Count changes by (+alloc - retire).
- Full: count==DEPTH drops req_ready_o unless the request coalesces.
- Empty: mem_valid_o=0 and empty_o=1.

## Timing
- Reset values: all entries FREE, all pointers 0, count 0, ack_err_o 0, mem_valid_o 0, req_ready_o 1, empty_o 1, chk_hit_o 0.
- Reset asserted mid-operation discards all entries next edge regardless of in-flight writes; late acks after reset set ack_err_o.
- Accept-to-mem_valid_o latency: 1 cycle when the buffer was empty.
- Ack-to-req_ready_o recovery from full: 1 cycle. The ack frees the entry at the edge; count drops at the head advance. When the acked entry is the head, both happen on the same edge.
- chk_hit_o reflects register state; it does not see a store accepted in the same cycle.

## Configuration
- WT_STORE_WBUF_COALESCE_EN defined: a request whose word address matches the youngest PEND entry is merged into it.
  - The target entry must not be entry[iss] while mem_valid_o is high.
  - Merge rule: data lanes with req_be_i set are overwritten, and be |= req_be_i.
  - No allocation occurs; this is allowed even when full.
- Macro undefined: coalesce_hit is tied to 0 and every accepted store allocates an entry.

## Test plan
- Reset, then single store addr 0x8000_0010, be 0xFF, data 0x1122334455667788 → mem_valid_o next cycle, mem_addr_o 0x8000_0010, mem_id_o 0; after ack id 0, empty_o=1 within 2 cycles.
- DEPTH=4, hold mem_ready_i=0, send 5 stores to distinct words → 4 accepted, req_ready_o=0 on the 5th. Release mem_ready_i and ack id 0 → 5th accepted 1 cycle after the ack.
- Issue ids 0,1,2, ack in order 2,0,1 → head retires 0 after the second ack and 1,2 after the third; count=0 and no ack_err_o.
- With COALESCE_EN and mem_ready_i=0: entry[iss] holds word 0x100. Two further stores to word 0x200 (be 0x0F, then 0xF0) → a single mem write with be 0xFF and merged data, ID 1. Without the macro → two writes.
- Store pending at 0x8000_0040; chk_addr_i 0x8000_0044 (same word, DATA_W=64) → chk_hit_o=1. After its ack retires → 0.
- Ack id 3 while entry 3 is FREE → ack_err_o=1, held until rst_i; no state change.
